// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Groups the fetch stage's signals into one bundle: the hazard
//               and branch controls from later stages, the instruction memory
//               read port, the IF/ID pipeline register and the debug counters.
//               master : seen from fetch_stage (drives memory port and IF/ID)
//               slave  : seen from the surrounding pipeline / memory
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_read_data;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    modport master (
        input  freeze, branch_taken, branch_address, imem_read_data,
        output imem_read, imem_address, pc_out, instruction_out, valid_out,
               fetch_count, stall_count
    );

    modport slave (
        output freeze, branch_taken, branch_address, imem_read_data,
        input  imem_read, imem_address, pc_out, instruction_out, valid_out,
               fetch_count, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, drives the instruction
//               memory read port and holds the IF/ID register. After reset a
//               single BOOT cycle lets the memory image settle before the
//               first fetch. Taken branches flush the fetched slot; freeze
//               holds PC and IF/ID. Fetch and stall cycles are counted.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - fetch_stage_if.master (controls, imem port, IF/ID,
//                      debug counters)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'hE000_0000,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_stage_if.master   bus
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instruction;
    logic        r_valid;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    logic [31:0] w_pc_next;
    logic [31:0] w_pc_out_next;
    logic [31:0] w_instruction_next;
    logic        w_valid_next;
    logic [31:0] w_fetch_count_next;
    logic [31:0] w_stall_count_next;
    logic [31:0] w_pc_plus4;

    // Wraps silently at the top of the address space.
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_pc_out      <= 32'd0;
            r_instruction <= NOP_INSTR;
            r_valid       <= 1'b0;
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pc_out      <= w_pc_out_next;
            r_instruction <= w_instruction_next;
            r_valid       <= w_valid_next;
            r_fetch_count <= w_fetch_count_next;
            r_stall_count <= w_stall_count_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_pc_out_next      = r_pc_out;
        w_instruction_next = r_instruction;
        w_valid_next       = r_valid;
        w_fetch_count_next = r_fetch_count;
        w_stall_count_next = r_stall_count;

        case (r_state)
            ST_BOOT: begin
                // Controls are ignored; only the state advances.
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.branch_taken) begin
                    // Branch beats freeze: the slot fetched this cycle is
                    // on the wrong path, so a bubble replaces it.
                    w_pc_next          = {bus.branch_address[31:2], 2'b00};
                    w_pc_out_next      = 32'd0;
                    w_instruction_next = NOP_INSTR;
                    w_valid_next       = 1'b0;
                end else if (bus.freeze) begin
                    w_stall_count_next = r_stall_count + 32'd1;
                end else begin
                    w_pc_next          = w_pc_plus4;
                    w_pc_out_next      = w_pc_plus4;
                    w_instruction_next = bus.imem_read_data;
                    w_valid_next       = 1'b1;
                    w_fetch_count_next = r_fetch_count + 32'd1;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // Read enable follows reset directly so it drops the moment rst rises
    // and is already high during the BOOT cycle.
    assign bus.imem_read       = ~rst;
    assign bus.imem_address    = r_pc;
    assign bus.pc_out          = r_pc_out;
    assign bus.instruction_out = r_instruction;
    assign bus.valid_out       = r_valid;
    assign bus.fetch_count     = r_fetch_count;
    assign bus.stall_count     = r_stall_count;

endmodule
`default_nettype wire
